// File: rtl/ni_injection_queue.sv
// Network-interface injection queue: buffers generator flits in a small FIFO and
// forwards them to the router's local port under credit-based flow control.

package router_pkg;
  localparam int FLIT_SIZE = 16;
endpackage

module ni_injection_queue
  import router_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [FLIT_SIZE-1:0] i_flit,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [FLIT_SIZE-1:0] o_flit,
  output logic                 o_valid,
  input  logic                 i_credit,
  output logic                 o_empty,
  output logic                 o_full,
  output logic [CNT_W-1:0]     o_pkt_count,
  output logic                 o_credit_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(CREDITS + 1);

  localparam logic [PW:0]    OCC_FULL = (PW + 1)'(DEPTH);
  localparam logic [PW:0]    OCC_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0]  CRED_ONE = CW'(1);
  localparam logic [CNT_W-1:0] PKT_ONE = CNT_W'(1);

  logic [FLIT_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW:0]          occupancy;
  logic [CW-1:0]        credit_cnt;

  logic                 push;
  logic                 send;
  logic [FLIT_SIZE-1:0] head_flit;

  assign o_empty   = (occupancy == '0);
  assign o_full    = (occupancy == OCC_FULL);
  assign o_ready   = !o_full;
  assign push      = i_valid && o_ready;
  assign send      = !o_empty && (credit_cnt != '0);
  assign head_flit = mem[rd_ptr];

  // Storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_flit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      credit_cnt   <= CRED_MAX;
      o_valid      <= 1'b0;
      o_flit       <= '0;
      o_pkt_count  <= '0;
      o_credit_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (push && !send) begin
        occupancy <= occupancy + OCC_ONE;
      end else if (send && !push) begin
        occupancy <= occupancy - OCC_ONE;
      end

      o_valid <= send;
      if (send) begin
        o_flit <= head_flit;
        rd_ptr <= rd_ptr + PTR_ONE;
        // Type bit [MSB] set means tail or head+tail: the packet is complete.
        if (head_flit[FLIT_SIZE-1]) begin
          o_pkt_count <= o_pkt_count + PKT_ONE;
        end
      end

      if (i_credit && !send) begin
        if (credit_cnt == CRED_MAX) begin
          o_credit_err <= 1'b1;
        end else begin
          credit_cnt <= credit_cnt + CRED_ONE;
        end
      end else if (send && !i_credit) begin
        credit_cnt <= credit_cnt - CRED_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ni_injection_queue.sv
// Randomised and directed bench for ni_injection_queue against a queue-based
// reference model of the flit FIFO, credit counter and packet counter.

module tb_ni_injection_queue;
  import router_pkg::*;

  localparam int FS      = FLIT_SIZE;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [FS-1:0] i_flit;
  logic          i_valid;
  logic          i_credit;
  logic          o_ready, o_valid, o_empty, o_full, o_credit_err;
  logic [FS-1:0] o_flit;
  logic [15:0]   o_pkt_count;
  logic          s_ready, s_valid, s_empty, s_full, s_credit_err;
  logic [FS-1:0] s_flit;
  logic [1:0]    s_pkt_count;

  always #5 clk = ~clk;

  ni_injection_queue #(.DEPTH(DEPTH), .CREDITS(CREDITS), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .i_flit(i_flit), .i_valid(i_valid),
    .o_ready(o_ready), .o_flit(o_flit), .o_valid(o_valid), .i_credit(i_credit),
    .o_empty(o_empty), .o_full(o_full), .o_pkt_count(o_pkt_count),
    .o_credit_err(o_credit_err)
  );

  // Narrow-counter copy sharing the same stimulus, used to see the counter wrap.
  ni_injection_queue #(.DEPTH(DEPTH), .CREDITS(CREDITS), .CNT_W(2)) u_small (
    .clk(clk), .reset_n(reset_n), .i_flit(i_flit), .i_valid(i_valid),
    .o_ready(s_ready), .o_flit(s_flit), .o_valid(s_valid), .i_credit(i_credit),
    .o_empty(s_empty), .o_full(s_full), .o_pkt_count(s_pkt_count),
    .o_credit_err(s_credit_err)
  );

  int checks = 0;
  int errors = 0;

  logic [FS-1:0] fifo[$];
  logic [FS-1:0] src[$];
  int            credits;
  bit            err_flag;
  int            pkts;
  bit            exp_valid;
  logic [FS-1:0] exp_flit;
  logic [3:0]    ret_sr;
  bit            auto_ret;
  int            nvalid;
  bit            saw_full;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [FS-1:0] mkFlit(input logic [1:0] kind);
    logic [FS-1:0] f;
    f = FS'($urandom);
    f[FS-1:FS-2] = kind;
    return f;
  endfunction

  task automatic compareAll();
    checkOutput("o_valid", 64'(o_valid), 64'(exp_valid));
    checkOutput("o_flit", 64'(o_flit), 64'(exp_flit));
    checkOutput("o_empty", 64'(o_empty), 64'(fifo.size() == 0));
    checkOutput("o_full", 64'(o_full), 64'(fifo.size() == DEPTH));
    checkOutput("o_ready", 64'(o_ready), 64'(fifo.size() != DEPTH));
    checkOutput("o_credit_err", 64'(o_credit_err), 64'(err_flag));
    checkOutput("o_pkt_count", 64'(o_pkt_count), 64'(pkts % 65536));
    checkOutput("small_pkt_count", 64'(s_pkt_count), 64'(pkts % 4));
    checkOutput("small_valid", 64'(s_valid), 64'(exp_valid));
  endtask

  // One clock: drive inputs, let the model follow the edge, compare at negedge.
  task automatic applyStimulus(input bit cred, input bit gate);
    bit snd;
    bit acc;
    logic [FS-1:0] f;
    i_valid  = gate && (src.size() > 0);
    i_flit   = (src.size() > 0) ? src[0] : FS'($urandom);
    i_credit = cred | (auto_ret & ret_sr[0]);
    @(posedge clk);
    acc = i_valid && (fifo.size() < DEPTH);
    snd = (fifo.size() > 0) && (credits > 0);
    if (snd) begin
      f = fifo.pop_front();
      exp_valid = 1'b1;
      exp_flit  = f;
      if (f[FS-1]) pkts++;
    end else begin
      exp_valid = 1'b0;
    end
    if (i_credit && !snd) begin
      if (credits == CREDITS) err_flag = 1'b1;
      else credits++;
    end else if (snd && !i_credit) begin
      credits--;
    end
    if (acc) begin
      fifo.push_back(i_flit);
      src.delete(0);
    end
    ret_sr = ret_sr >> 1;
    if (snd) ret_sr[1] = 1'b1;
    @(negedge clk);
    if (o_valid) nvalid++;
    if (o_full) saw_full = 1'b1;
    compareAll();
  endtask

  task automatic doReset();
    reset_n  = 1'b0;
    i_valid  = 1'b1;
    i_flit   = mkFlit(2'b11);
    fifo.delete();
    src.delete();
    credits   = CREDITS;
    err_flag  = 1'b0;
    pkts      = 0;
    exp_valid = 1'b0;
    exp_flit  = '0;
    ret_sr    = '0;
    for (int k = 0; k < 4; k++) begin
      i_credit = k[0];
      @(negedge clk);
      compareAll();
    end
    i_valid  = 1'b0;
    i_credit = 1'b0;
    reset_n  = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b1;
    i_valid  = 1'b0;
    i_credit = 1'b0;
    i_flit   = '0;
    auto_ret = 1'b0;
    @(negedge clk);
    doReset();
    for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b0);

    // Streaming packet with the router returning credits two cycles later.
    auto_ret = 1'b1;
    nvalid   = 0;
    src.push_back(mkFlit(2'b01));
    src.push_back(mkFlit(2'b00));
    src.push_back(mkFlit(2'b00));
    src.push_back(mkFlit(2'b10));
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1);
    checkOutput("stream_valid_count", 64'(nvalid), 64'd4);
    checkOutput("stream_pkt_count", 64'(o_pkt_count), 64'd1);

    // Credit starvation: only four flits leave until credits come back.
    auto_ret = 1'b0;
    nvalid   = 0;
    saw_full = 1'b0;
    for (int k = 0; k < 8; k++) src.push_back(mkFlit(2'(k)));
    for (int k = 0; k < 14; k++) applyStimulus(1'b0, 1'b1);
    checkOutput("starve_valid_count", 64'(nvalid), 64'd4);
    checkOutput("starve_saw_full", 64'(saw_full), 64'd1);
    nvalid = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("starve_resume_count", 64'(nvalid), 64'd4);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0);

    // Wrap-around bursts with credits returned automatically.
    auto_ret = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) src.push_back(mkFlit(2'(k)));
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1);
      for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0);
    end
    checkOutput("wrap_empty", 64'(o_empty), 64'd1);

    // Bring credits down to one, then return a credit on the same edge as a send.
    auto_ret = 1'b0;
    for (int k = 0; k < 3; k++) src.push_back(mkFlit(2'b11));
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b1);
    src.push_back(mkFlit(2'b11));
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("simul_send_valid", 64'(o_valid), 64'd1);
    checkOutput("simul_no_err", 64'(o_credit_err), 64'd0);

    // Refill to the maximum, then overflow once.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0);
    checkOutput("pre_overflow_err", 64'(o_credit_err), 64'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("overflow_err", 64'(o_credit_err), 64'd1);
    nvalid = 0;
    for (int k = 0; k < 5; k++) src.push_back(mkFlit(2'b11));
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b1);
    checkOutput("overflow_saturated_sends", 64'(nvalid), 64'd4);

    // Reset mid-operation, then wrap the 2-bit packet counter.
    doReset();
    checkOutput("reset_clears_err", 64'(o_credit_err), 64'd0);
    auto_ret = 1'b1;
    for (int k = 0; k < 5; k++) src.push_back(mkFlit(2'b11));
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b1);
    checkOutput("small_wrap_count", 64'(s_pkt_count), 64'd1);
    checkOutput("wide_count", 64'(o_pkt_count), 64'd5);

    // Random traffic with random extra credit pulses.
    for (int k = 0; k < 400; k++) begin
      if (src.size() < 3) src.push_back(mkFlit(2'($urandom)));
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
